// File: rtl/rr_arb_pkg.sv
// -----------------------------------------------------------------------------
// rr_arb_pkg
// Shared definitions for the aged fixed-priority / round-robin server arbiter:
//   - FSM state encodings (ST_IDLE / ST_OFFER / ST_BUSY) and the state enum
//   - encodings of the 'active' output (ACT_NONE / ACT_H / ACT_L)
// -----------------------------------------------------------------------------
package rr_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OFFER = 2'd1;
  localparam logic [1:0] ST_BUSY  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_OFFER = ST_OFFER,
    S_BUSY  = ST_BUSY
  } state_t;

  localparam logic [1:0] ACT_NONE = 2'b00;
  localparam logic [1:0] ACT_H    = 2'b01;
  localparam logic [1:0] ACT_L    = 2'b10;

endpackage : rr_arb_pkg

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: returns the first requesting channel at or
// above the pointer, wrapping modulo N.
// Ports:
//   i_req  [N-1:0]     request vector
//   i_ptr  [CH_W-1:0]  round-robin pointer (always < N)
//   o_any              at least one request present
//   o_idx  [CH_W-1:0]  index of the chosen channel (0 when o_any = 0)
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int N    = 3,
  parameter int CH_W = 4
) (
  input  logic [N-1:0]    i_req,
  input  logic [CH_W-1:0] i_ptr,
  output logic            o_any,
  output logic [CH_W-1:0] o_idx
);

  // Each channel's distance from the pointer in the wrap-around order; the
  // requesting channel with the smallest distance wins. Constant-index loop
  // keeps this free of variable-width bit selects.
  always_comb begin
    int best_d;
    int d;
    // NOTE: every combinational output gets a default before any conditional
    // assignment, otherwise synthesis infers a latch for the unassigned paths.
    o_any  = 1'b0;
    o_idx  = '0;
    best_d = N;
    d      = 0;
    for (int i = 0; i < N; i++) begin
      d = (i >= int'(i_ptr)) ? (i - int'(i_ptr)) : (i + N - int'(i_ptr));
      if (i_req[i] && (d < best_d)) begin
        best_d = d;
        o_any  = 1'b1;
        o_idx  = CH_W'(i);
      end
    end
  end

endmodule : rr_pick

// File: rtl/rr_fp_arbiter_aged.sv
// -----------------------------------------------------------------------------
// rr_fp_arbiter_aged
// Two-class server arbiter for the queue-server fabric. High class (H) is
// strictly preferred over low class (L) except when the ageing guard is due;
// round-robin within each class. Grants are offered (OFFER) until the owner
// raises go (BUSY), withdraws its ready, or the go-timeout expires.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   bool_ready_H/L           per-channel packet pending
//   bool_go_H/L              per-channel transmitting
//   ena_n_H/L                active-low grants (registered)
//   active                   00 none, 01 H, 10 L (registered)
//   channel                  granted index within its class (registered)
//   timeout                  1-cycle pulse when a grant is withdrawn by timeout
//   conflict                 registered: more than one go high last cycle
// -----------------------------------------------------------------------------
module rr_fp_arbiter_aged
  import rr_arb_pkg::*;
#(
  parameter int N_H        = 1,
  parameter int N_L        = 3,
  parameter int CH_W       = 4,
  parameter int AGE_LIMIT  = 8,
  parameter int GO_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_H-1:0]  bool_ready_H,
  input  logic [N_H-1:0]  bool_go_H,
  input  logic [N_L-1:0]  bool_ready_L,
  input  logic [N_L-1:0]  bool_go_L,
  output logic [N_H-1:0]  ena_n_H,
  output logic [N_L-1:0]  ena_n_L,
  output logic [1:0]      active,
  output logic [CH_W-1:0] channel,
  output logic            timeout,
  output logic            conflict
);

  localparam int AGE_W  = (AGE_LIMIT  > 0) ? $clog2(AGE_LIMIT + 1)  : 1;
  localparam int TCNT_W = (GO_TIMEOUT > 0) ? $clog2(GO_TIMEOUT + 1) : 1;
  localparam int N_ALL  = N_H + N_L;

  state_t            r_state,    w_state_nxt;
  logic [CH_W-1:0]   r_ptr_h,    w_ptr_h_nxt;
  logic [CH_W-1:0]   r_ptr_l,    w_ptr_l_nxt;
  logic [CH_W-1:0]   r_chan,     w_chan_nxt;
  logic [1:0]        r_active,   w_active_nxt;
  logic [N_H-1:0]    r_ena_n_h,  w_ena_n_h_nxt;
  logic [N_L-1:0]    r_ena_n_l,  w_ena_n_l_nxt;
  logic [AGE_W-1:0]  r_age,      w_age_nxt;
  logic [TCNT_W-1:0] r_tcnt,     w_tcnt_nxt;
  logic              r_timeout,  w_timeout_nxt;
  logic              r_conflict;

  logic            w_any_h, w_any_l, w_pick_l, w_age_due, w_tmo_hit;
  logic [CH_W-1:0] w_idx_h, w_idx_l, w_ptr_h_adv, w_ptr_l_adv;
  logic [AGE_W-1:0] w_age_inc;
  logic            w_sel_go, w_sel_rdy, w_multi_go;
  logic [N_ALL-1:0] w_go_all;

  rr_pick #(.N(N_H), .CH_W(CH_W)) u_pick_h (
    .i_req(bool_ready_H), .i_ptr(r_ptr_h), .o_any(w_any_h), .o_idx(w_idx_h)
  );

  rr_pick #(.N(N_L), .CH_W(CH_W)) u_pick_l (
    .i_req(bool_ready_L), .i_ptr(r_ptr_l), .o_any(w_any_l), .o_idx(w_idx_l)
  );

  // Class choice: the guard forces L only once H has won AGE_LIMIT decisions
  // while L was waiting.
  assign w_age_due = (AGE_LIMIT != 0) && (r_age == AGE_W'(AGE_LIMIT));
  assign w_pick_l  = w_any_l && (w_age_due || !w_any_h);
  assign w_age_inc = w_age_due ? r_age : r_age + AGE_W'(1);
  assign w_tmo_hit = (GO_TIMEOUT != 0) && (r_tcnt == TCNT_W'(GO_TIMEOUT - 1));

  // Pointer advance past the current owner; explicit compare handles
  // non-power-of-two class sizes.
  assign w_ptr_h_adv = (r_chan == CH_W'(N_H - 1)) ? '0 : r_chan + CH_W'(1);
  assign w_ptr_l_adv = (r_chan == CH_W'(N_L - 1)) ? '0 : r_chan + CH_W'(1);

  // go/ready of the channel currently holding the grant.
  always_comb begin
    w_sel_go  = 1'b0;
    w_sel_rdy = 1'b0;
    for (int i = 0; i < N_H; i++) begin
      if (r_active == ACT_H && r_chan == CH_W'(i)) begin
        w_sel_go  = bool_go_H[i];
        w_sel_rdy = bool_ready_H[i];
      end
    end
    for (int i = 0; i < N_L; i++) begin
      if (r_active == ACT_L && r_chan == CH_W'(i)) begin
        w_sel_go  = bool_go_L[i];
        w_sel_rdy = bool_ready_L[i];
      end
    end
  end

  // More than one bit set: clearing the lowest set bit leaves something.
  assign w_go_all   = {bool_go_H, bool_go_L};
  assign w_multi_go = |(w_go_all & (w_go_all - N_ALL'(1)));

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_h_nxt   = r_ptr_h;
    w_ptr_l_nxt   = r_ptr_l;
    w_chan_nxt    = r_chan;
    w_active_nxt  = r_active;
    w_ena_n_h_nxt = r_ena_n_h;
    w_ena_n_l_nxt = r_ena_n_l;
    w_age_nxt     = r_age;
    w_tcnt_nxt    = r_tcnt;
    w_timeout_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_any_h || w_any_l) begin
          w_state_nxt = S_OFFER;
          w_tcnt_nxt  = '0;
          if (w_pick_l) begin
            w_active_nxt = ACT_L;
            w_chan_nxt   = w_idx_l;
            for (int i = 0; i < N_L; i++) w_ena_n_l_nxt[i] = (w_idx_l != CH_W'(i));
            w_age_nxt    = '0;
          end else begin
            w_active_nxt = ACT_H;
            w_chan_nxt   = w_idx_h;
            for (int i = 0; i < N_H; i++) w_ena_n_h_nxt[i] = (w_idx_h != CH_W'(i));
            w_age_nxt    = w_any_l ? w_age_inc : '0;
          end
        end
      end

      S_OFFER: begin
        if (w_sel_go) begin
          w_state_nxt = S_BUSY;
        end else if (!w_sel_rdy || w_tmo_hit) begin
          w_state_nxt   = S_IDLE;
          w_active_nxt  = ACT_NONE;
          w_chan_nxt    = '0;
          w_ena_n_h_nxt = '1;
          w_ena_n_l_nxt = '1;
          // A withdrawn request keeps its turn; a timed-out one loses it.
          if (w_sel_rdy) begin
            w_timeout_nxt = 1'b1;
            if (r_active == ACT_H) w_ptr_h_nxt = w_ptr_h_adv;
            else                   w_ptr_l_nxt = w_ptr_l_adv;
          end
        end else begin
          w_tcnt_nxt = r_tcnt + TCNT_W'(1);
        end
      end

      S_BUSY: begin
        if (!w_sel_go) begin
          w_state_nxt   = S_IDLE;
          w_active_nxt  = ACT_NONE;
          w_chan_nxt    = '0;
          w_ena_n_h_nxt = '1;
          w_ena_n_l_nxt = '1;
          if (r_active == ACT_H) w_ptr_h_nxt = w_ptr_h_adv;
          else                   w_ptr_l_nxt = w_ptr_l_adv;
        end
      end

      default: begin
        w_state_nxt   = S_IDLE;
        w_active_nxt  = ACT_NONE;
        w_chan_nxt    = '0;
        w_ena_n_h_nxt = '1;
        w_ena_n_l_nxt = '1;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of the order of statements.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ptr_h    <= '0;
      r_ptr_l    <= '0;
      r_chan     <= '0;
      r_active   <= ACT_NONE;
      r_ena_n_h  <= '1;
      r_ena_n_l  <= '1;
      r_age      <= '0;
      r_tcnt     <= '0;
      r_timeout  <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr_h    <= w_ptr_h_nxt;
      r_ptr_l    <= w_ptr_l_nxt;
      r_chan     <= w_chan_nxt;
      r_active   <= w_active_nxt;
      r_ena_n_h  <= w_ena_n_h_nxt;
      r_ena_n_l  <= w_ena_n_l_nxt;
      r_age      <= w_age_nxt;
      r_tcnt     <= w_tcnt_nxt;
      r_timeout  <= w_timeout_nxt;
      r_conflict <= w_multi_go;
    end
  end

  assign ena_n_H  = r_ena_n_h;
  assign ena_n_L  = r_ena_n_l;
  assign active   = r_active;
  assign channel  = r_chan;
  assign timeout  = r_timeout;
  assign conflict = r_conflict;

endmodule : rr_fp_arbiter_aged

// File: tb/tb_rr_fp_arbiter_aged.sv
// -----------------------------------------------------------------------------
// tb_rr_fp_arbiter_aged
// Directed bench for rr_fp_arbiter_aged (N_H=1, N_L=3, AGE_LIMIT=2,
// GO_TIMEOUT=4). Expected grants are queued as stimulus is issued; a monitor
// pops one entry per new grant and compares class/channel.
// -----------------------------------------------------------------------------
module tb_rr_fp_arbiter_aged;
  import rr_arb_pkg::*;

  localparam int N_H        = 1;
  localparam int N_L        = 3;
  localparam int CH_W       = 4;
  localparam int AGE_LIMIT  = 2;
  localparam int GO_TIMEOUT = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N_H-1:0]  bool_ready_H = '0, bool_go_H = '0;
  logic [N_L-1:0]  bool_ready_L = '0, bool_go_L = '0;
  logic [N_H-1:0]  ena_n_H;
  logic [N_L-1:0]  ena_n_L;
  logic [1:0]      active;
  logic [CH_W-1:0] channel;
  logic            timeout, conflict;

  rr_fp_arbiter_aged #(
    .N_H(N_H), .N_L(N_L), .CH_W(CH_W),
    .AGE_LIMIT(AGE_LIMIT), .GO_TIMEOUT(GO_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .bool_ready_H(bool_ready_H), .bool_go_H(bool_go_H),
    .bool_ready_L(bool_ready_L), .bool_go_L(bool_go_L),
    .ena_n_H(ena_n_H), .ena_n_L(ena_n_L),
    .active(active), .channel(channel),
    .timeout(timeout), .conflict(conflict)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]      act;
    logic [CH_W-1:0] ch;
  } grant_t;

  grant_t exp_q[$];
  int     n_vec = 0;
  int     n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_grant(input logic [1:0] a, input int ch);
    grant_t g;
    g.act = a;
    g.ch  = CH_W'(ch);
    exp_q.push_back(g);
  endtask

  // Monitor: a new grant is the first cycle with active != 00 after 00.
  logic [1:0] prev_act = ACT_NONE;
  always @(negedge clk) begin
    grant_t e;
    if (!rst && prev_act == ACT_NONE && active != ACT_NONE) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_unexpected: got grant act=%0h ch=%0h, expected none", active, channel);
      end else begin
        e = exp_q.pop_front();
        check("sb_grant", {26'd0, active, channel}, {26'd0, e.act, e.ch});
      end
    end
    prev_act = active;
  end

  task automatic set_go(input logic [1:0] a, input logic [CH_W-1:0] c, input logic v);
    for (int i = 0; i < N_H; i++) if (a == ACT_H && int'(c) == i) bool_go_H[i] = v;
    for (int i = 0; i < N_L; i++) if (a == ACT_L && int'(c) == i) bool_go_L[i] = v;
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (active != ACT_NONE) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("grant_wait_expired", 32'd0, 32'd1);
  endtask

  // Take the next grant, transmit for len cycles, then release it.
  task automatic serve(input int len, input bit last);
    bit ok;
    logic [1:0]      a;
    logic [CH_W-1:0] c;
    wait_grant(ok);
    if (!ok) return;
    a = active;
    c = channel;
    set_go(a, c, 1'b1);
    repeat (len) @(negedge clk);
    check("busy_hold", {30'd0, active}, {30'd0, a});
    set_go(a, c, 1'b0);
    if (last) begin
      bool_ready_H = '0;
      bool_ready_L = '0;
    end
    @(negedge clk);
    check("idle_gap", {30'd0, active}, {30'd0, ACT_NONE});
  endtask

  task automatic check_reset_outputs();
    check("rst_ena_n_H", 32'(ena_n_H), 32'h1);
    check("rst_ena_n_L", 32'(ena_n_L), 32'h7);
    check("rst_active",  32'(active),  32'h0);
    check("rst_channel", 32'(channel), 32'h0);
    check("rst_timeout", 32'(timeout), 32'h0);
    check("rst_conflict",32'(conflict),32'h0);
    check("rst_ptr_h",   32'(dut.r_ptr_h), 32'h0);
    check("rst_ptr_l",   32'(dut.r_ptr_l), 32'h0);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) begin
      @(negedge clk);
      check_reset_outputs();
    end
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. Reset held 3 cycles with every ready asserted; H preferred afterwards.
    bool_ready_H = '1;
    bool_ready_L = '1;
    do_reset(3);
    expect_grant(ACT_H, 0);
    serve(1, 1);

    // 2. L only, round robin with wrap across a non-power-of-two class.
    do_reset(1);
    expect_grant(ACT_L, 0);
    expect_grant(ACT_L, 1);
    expect_grant(ACT_L, 2);
    expect_grant(ACT_L, 0);
    bool_ready_L = 3'b111;
    serve(5, 0);
    serve(5, 0);
    serve(5, 0);
    serve(5, 1);

    // 3. Constant H load with L1 pending: ageing forces L1 every third grant.
    do_reset(1);
    expect_grant(ACT_H, 0);
    expect_grant(ACT_H, 0);
    expect_grant(ACT_L, 1);
    expect_grant(ACT_H, 0);
    expect_grant(ACT_H, 0);
    expect_grant(ACT_L, 1);
    bool_ready_H = 1'b1;
    bool_ready_L = 3'b010;
    for (int i = 0; i < 5; i++) serve(2, 0);
    serve(2, 1);

    // 4. H arrives while L2 is transmitting: no pre-emption.
    do_reset(1);
    expect_grant(ACT_L, 2);
    bool_ready_L = 3'b100;
    begin
      bit ok;
      wait_grant(ok);
      bool_go_L[2] = 1'b1;
      @(negedge clk);
      bool_ready_H = 1'b1;
      repeat (3) begin
        @(negedge clk);
        check("noprempt_ena_n_L", 32'(ena_n_L), 32'h3);
        check("noprempt_ena_n_H", 32'(ena_n_H), 32'h1);
      end
      expect_grant(ACT_H, 0);
      bool_go_L[2]  = 1'b0;
      bool_ready_L  = '0;
      @(negedge clk);
      check("l2_release_ena_n_L", 32'(ena_n_L), 32'h7);
      check("l2_release_active",  32'(active),  32'h0);
      @(negedge clk);
      check("h_after_idle_ena_n_H", 32'(ena_n_H), 32'h0);
      serve(2, 1);
    end

    // 5. Go never raised on L0: grant held exactly GO_TIMEOUT cycles.
    do_reset(1);
    expect_grant(ACT_L, 0);
    expect_grant(ACT_L, 1);
    bool_ready_L = 3'b011;
    begin
      bit ok;
      wait_grant(ok);
      check("tmo_cycle1_ena_n_L", 32'(ena_n_L), 32'h6);
      for (int i = 2; i <= GO_TIMEOUT; i++) begin
        @(negedge clk);
        check("tmo_hold_ena_n_L", 32'(ena_n_L), 32'h6);
        check("tmo_hold_timeout", 32'(timeout), 32'h0);
      end
      @(negedge clk);
      check("tmo_drop_ena_n_L", 32'(ena_n_L), 32'h7);
      check("tmo_pulse",        32'(timeout), 32'h1);
      bool_ready_L[0] = 1'b0;
      @(negedge clk);
      check("tmo_pulse_end",    32'(timeout), 32'h0);
      check("tmo_next_ena_n_L", 32'(ena_n_L), 32'h5);
      serve(1, 1);
    end

    // 6. Conflict flag: single go is fine, two gos flag the next cycle.
    do_reset(1);
    bool_go_H[0] = 1'b1;
    @(negedge clk);
    check("conflict_single", 32'(conflict), 32'h0);
    bool_go_L[1] = 1'b1;
    @(negedge clk);
    check("conflict_set", 32'(conflict), 32'h1);
    bool_go_H = '0;
    bool_go_L = '0;
    @(negedge clk);
    check("conflict_clear", 32'(conflict), 32'h0);
    check("conflict_no_grant", 32'(active), 32'h0);

    // 7. Withdrawn offer keeps the pointer: L1 still wins over L2 next time.
    do_reset(1);
    expect_grant(ACT_L, 1);
    bool_ready_L = 3'b010;
    begin
      bit ok;
      wait_grant(ok);
      bool_ready_L = '0;
      @(negedge clk);
      check("withdraw_active",  32'(active),  32'h0);
      check("withdraw_timeout", 32'(timeout), 32'h0);
    end
    expect_grant(ACT_L, 1);
    bool_ready_L = 3'b110;
    serve(1, 1);

    // 8. Reset mid-transmission drops the grant regardless of go.
    do_reset(1);
    expect_grant(ACT_L, 0);
    bool_ready_L = 3'b001;
    begin
      bit ok;
      wait_grant(ok);
      bool_go_L[0] = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_reset_outputs();
      bool_go_L    = '0;
      bool_ready_L = '0;
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
    end

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_rr_fp_arbiter_aged
